// File: rtl/instr_fetch_unit_if.sv
// Bundles for the fetch unit: instruction-memory read port and
// the decode-side handoff of the held instruction.

interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

interface fetch_dec_if;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch;
    logic        zero;
    logic        jump;

    modport master (
        output instr,
        output opcode,
        output instr_pc,
        output instr_valid,
        input  instr_ready,
        input  branch,
        input  zero,
        input  jump
    );

    modport slave (
        input  instr,
        input  opcode,
        input  instr_pc,
        input  instr_valid,
        output instr_ready,
        output branch,
        output zero,
        output jump
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: IDLE/FETCH/HOLD sequencer that reads one word,
// holds it for decode, and picks the next PC at handoff.

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      fetch_en,
    instr_fetch_unit_if.master        imem,
    fetch_dec_if.master               dec,
    output logic [31:0]               instr_count
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] pc;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic [31:0] count_q;

    logic        fetch_done;
    logic        handoff;

    logic [31:0] pc_plus4;
    logic [31:0] br_off;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
    logic [31:0] next_pc;

    assign fetch_done = (state == FETCH) && imem.imem_ack;
    assign handoff    = (state == HOLD) && dec.instr_ready;

    // Next-PC targets are all relative to the held word, not the fetch PC.
    assign pc_plus4   = instr_pc_q + 32'd4;
    assign br_off     = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign br_target  = pc_plus4 + br_off;
    assign jmp_target = {pc_plus4[31:28], instr_q[25:0], 2'b00};

    // Jump wins over a taken branch when both are flagged.
    always_comb begin
        next_pc = pc_plus4;
        priority case (1'b1)
            dec.jump:               next_pc = jmp_target;
            dec.branch && dec.zero: next_pc = br_target;
            default:                next_pc = pc_plus4;
        endcase
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (fetch_en) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (imem.imem_ack) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (dec.instr_ready) begin
                    state_nxt = fetch_en ? FETCH : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        imem.imem_req   = 1'b0;
        dec.instr_valid = 1'b0;
        unique case (state)
            FETCH:   imem.imem_req   = 1'b1;
            HOLD:    dec.instr_valid = 1'b1;
            default: begin
                imem.imem_req   = 1'b0;
                dec.instr_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            instr_q    <= 32'h0;
            instr_pc_q <= 32'h0;
            count_q    <= 32'h0;
        end else begin
            state <= state_nxt;
            if (fetch_done) begin
                instr_q    <= imem.imem_rdata;
                instr_pc_q <= pc;
            end
            if (handoff) begin
                pc      <= next_pc;
                count_q <= count_q + 32'd1;
            end
        end
    end

    assign imem.imem_addr = pc;
    assign dec.instr      = instr_q;
    assign dec.opcode     = instr_q[31:26];
    assign dec.instr_pc   = instr_pc_q;
    assign instr_count    = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a queue scoreboard
// for request addresses and delivered instructions.

module tb_instr_fetch_unit;

    logic clk = 1'b0;
    logic reset;
    logic fetch_en;
    logic [31:0] instr_count;

    instr_fetch_unit_if imem ();
    fetch_dec_if        dec ();

    instr_fetch_unit #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_en   (fetch_en),
        .imem       (imem),
        .dec        (dec),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] addr_q[$];
    logic [63:0] ins_q[$];

    logic [31:0] pc_m;
    logic [31:0] cnt_m;
    logic [31:0] cur_w;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: new requests and newly valid instructions are checked
    // against what the stimulus queued.
    logic req_prev = 1'b0;
    logic val_prev = 1'b0;
    always @(negedge clk) begin
        logic [63:0] e;
        logic [31:0] a;
        if ((imem.imem_req === 1'b1) && !req_prev) begin
            if (addr_q.size() == 0) begin
                chk("unexpected_req", imem.imem_addr, 32'hxxxx_xxxx);
            end else begin
                a = addr_q.pop_front();
                chk("sb_req_addr", imem.imem_addr, a);
            end
        end
        if ((dec.instr_valid === 1'b1) && !val_prev) begin
            if (ins_q.size() == 0) begin
                chk("unexpected_valid", dec.instr, 32'hxxxx_xxxx);
            end else begin
                e = ins_q.pop_front();
                chk("sb_instr", dec.instr, e[63:32]);
                chk("sb_instr_pc", dec.instr_pc, e[31:0]);
                chk("sb_opcode", {26'h0, dec.opcode}, {26'h0, e[63:58]});
            end
        end
        req_prev = (imem.imem_req === 1'b1);
        val_prev = (dec.instr_valid === 1'b1);
    end

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        pc_m  = 32'h0;
        cnt_m = 32'h0;
        chk("rst_req", {31'h0, imem.imem_req}, 32'h0);
        chk("rst_valid", {31'h0, dec.instr_valid}, 32'h0);
        chk("rst_addr", imem.imem_addr, 32'h0);
        chk("rst_opcode", {26'h0, dec.opcode}, 32'h0);
        chk("rst_instr", dec.instr, 32'h0);
        chk("rst_instr_pc", dec.instr_pc, 32'h0);
        chk("rst_count", instr_count, 32'h0);
    endtask

    task automatic start();
        fetch_en = 1'b1;
        addr_q.push_back(pc_m);
        @(negedge clk);
    endtask

    // Memory side: answer after 'waits' idle request cycles.
    task automatic serve(input logic [31:0] w, input int waits);
        for (int i = 0; i <= waits; i++) begin
            chk("ws_req", {31'h0, imem.imem_req}, 32'h1);
            chk("ws_addr", imem.imem_addr, pc_m);
            if (i == waits) begin
                imem.imem_ack   = 1'b1;
                imem.imem_rdata = w;
                ins_q.push_back({w, pc_m});
            end else begin
                imem.imem_rdata = ~w;
            end
            @(negedge clk);
        end
        imem.imem_ack = 1'b0;
        cur_w = w;
        chk("valid_after_ack", {31'h0, dec.instr_valid}, 32'h1);
    endtask

    // Stall for 'stall' cycles with noisy control inputs, then hand off.
    task automatic handoff(input logic b, input logic z, input logic j,
                           input logic en, input int stall,
                           input logic [31:0] exp_next);
        for (int i = 0; i < stall; i++) begin
            dec.instr_ready = 1'b0;
            dec.branch      = 1'b1;
            dec.zero        = 1'b1;
            dec.jump        = 1'b1;
            imem.imem_ack   = 1'b1;
            @(negedge clk);
            chk("bp_req", {31'h0, imem.imem_req}, 32'h0);
            chk("bp_instr", dec.instr, cur_w);
            chk("bp_instr_pc", dec.instr_pc, pc_m);
            chk("bp_count", instr_count, cnt_m);
        end
        imem.imem_ack   = 1'b0;
        dec.branch      = b;
        dec.zero        = z;
        dec.jump        = j;
        dec.instr_ready = 1'b1;
        fetch_en        = en;
        if (en) addr_q.push_back(exp_next);
        @(negedge clk);
        dec.instr_ready = 1'b0;
        dec.branch      = 1'b0;
        dec.zero        = 1'b0;
        dec.jump        = 1'b0;
        cnt_m++;
        pc_m = exp_next;
        chk("next_addr", imem.imem_addr, exp_next);
        chk("count", instr_count, cnt_m);
        chk("post_req", {31'h0, imem.imem_req}, {31'h0, en});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        fetch_en        = 1'b0;
        imem.imem_ack   = 1'b0;
        imem.imem_rdata = 32'h0;
        dec.instr_ready = 1'b0;
        dec.branch      = 1'b0;
        dec.zero        = 1'b0;
        dec.jump        = 1'b0;

        do_reset();

        start();
        serve(32'h0000_0020, 0);
        handoff(1'b0, 1'b0, 1'b0, 1'b1, 0, 32'h0000_0004);

        serve(32'h0800_0004, 0);
        handoff(1'b0, 1'b0, 1'b1, 1'b1, 0, 32'h0000_0010);

        serve(32'h1000_0003, 3);
        handoff(1'b1, 1'b1, 1'b0, 1'b1, 5, 32'h0000_0020);

        serve(32'h0800_0004, 0);
        handoff(1'b0, 1'b0, 1'b1, 1'b1, 0, 32'h0000_0010);

        serve(32'h1000_0003, 0);
        handoff(1'b1, 1'b0, 1'b0, 1'b1, 0, 32'h0000_0014);

        serve(32'h1000_FFFA, 0);
        handoff(1'b1, 1'b1, 1'b0, 1'b1, 0, 32'h0000_0000);

        serve(32'h1000_FFFE, 0);
        handoff(1'b1, 1'b1, 1'b0, 1'b1, 0, 32'hFFFF_FFFC);

        serve(32'h0000_0000, 0);
        handoff(1'b1, 1'b0, 1'b0, 1'b1, 0, 32'h0000_0000);

        // Climb to 0x4000_0000 in max-forward branch steps of 0x20000.
        for (int k = 0; k < 8192; k++) begin
            serve(32'h1000_7FFF, 0);
            handoff(1'b1, 1'b1, 1'b0, 1'b1, 0, pc_m + 32'h0002_0000);
        end
        chk("climb_pc", pc_m, 32'h4000_0000);

        serve(32'h0800_0040, 0);
        handoff(1'b1, 1'b1, 1'b1, 1'b0, 0, 32'h4000_0100);

        imem.imem_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        imem.imem_ack = 1'b0;
        chk("idle_req", {31'h0, imem.imem_req}, 32'h0);
        chk("idle_valid", {31'h0, dec.instr_valid}, 32'h0);
        chk("idle_instr", dec.instr, 32'h0800_0040);

        start();
        fetch_en = 1'b0;
        serve(32'hABCD_0000, 2);
        imem.imem_ack   = 1'b1;
        imem.imem_rdata = 32'h1234_5678;
        @(negedge clk);
        imem.imem_ack = 1'b0;
        chk("hold_ignores_ack", dec.instr, 32'hABCD_0000);
        chk("hold_opcode", {26'h0, dec.opcode}, 32'h0000_002A);
        handoff(1'b0, 1'b0, 1'b0, 1'b1, 0, 32'h4000_0104);

        reset           = 1'b1;
        imem.imem_ack   = 1'b1;
        imem.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        reset = 1'b0;
        pc_m  = 32'h0;
        cnt_m = 32'h0;
        chk("rst_fetch_req", {31'h0, imem.imem_req}, 32'h0);
        chk("rst_fetch_valid", {31'h0, dec.instr_valid}, 32'h0);
        chk("rst_fetch_instr", dec.instr, 32'h0);
        chk("rst_fetch_addr", imem.imem_addr, 32'h0);
        chk("rst_fetch_count", instr_count, 32'h0);
        @(negedge clk);
        imem.imem_ack = 1'b0;
        chk("late_ack_valid", {31'h0, dec.instr_valid}, 32'h0);
        chk("late_ack_instr", dec.instr, 32'h0);

        start();
        serve(32'h0000_0020, 0);
        handoff(1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0000_0004);

        @(negedge clk);
        chk("sb_addr_drained", addr_q.size(), 32'h0);
        chk("sb_ins_drained", ins_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
